// File: rtl/if_fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding word fetches,
// and hands each instruction to decode through a one-entry output buffer.
module if_fetch_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     IF_LEN       = 32,
    parameter int unsigned     IF_INC       = 4,
    parameter logic [XLEN-1:0] IF_BASE_ADDR = 32'h1000_0000,
    parameter logic [XLEN-1:0] IF_MAX_ADDR  = 32'h1000_3FFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_addr,
    input  logic              stall,
    output logic              mem_req,
    output logic [XLEN-1:0]   mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [IF_LEN-1:0] mem_rdata,
    output logic              if_valid,
    output logic [IF_LEN-1:0] if_instr,
    output logic [XLEN-1:0]   if_pc,
    output logic              fault,
    output logic [XLEN-1:0]   fault_addr,
    output logic [2:0]        dbg_state
);

    // Handshakes: a fetch transfers on a cycle with mem_req && mem_ack, and mem_req/mem_addr
    // hold until then (only a redirect may retarget early). Data returns on mem_rvalid at
    // least one cycle later. Decode takes the buffer on a cycle with if_valid && !stall.
    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    // Window checks use one extra bit so that pc+IF_INC-1 cannot wrap back into range.
    localparam logic [XLEN:0]   W_BASE = {1'b0, IF_BASE_ADDR};
    localparam logic [XLEN:0]   W_MAX  = {1'b0, IF_MAX_ADDR};
    localparam logic [XLEN:0]   W_SPAN = (XLEN+1)'(IF_INC - 1);
    localparam logic [XLEN-1:0] W_INC  = XLEN'(IF_INC);

    state_t              r_state;
    state_t              w_next_state;
    logic [XLEN-1:0]     r_pc;
    logic                r_drop;
    logic                r_if_valid;
    logic [IF_LEN-1:0]   r_if_instr;
    logic [XLEN-1:0]     r_if_pc;
    logic                r_fault;
    logic [XLEN-1:0]     r_fault_addr;

    logic [XLEN:0]       w_pc_ext;
    logic [XLEN:0]       w_pc_end;
    logic                w_pc_legal;
    logic                w_req;
    logic                w_redirect;
    logic                w_outstanding;
    logic                w_accept;
    logic                w_consume;

    assign w_pc_ext      = {1'b0, r_pc};
    assign w_pc_end      = w_pc_ext + W_SPAN;
    assign w_pc_legal    = (r_pc[1:0] == 2'b00) && (w_pc_ext >= W_BASE) && (w_pc_end <= W_MAX);
    assign w_req         = (r_state == S_REQ) && w_pc_legal;
    assign w_redirect    = redirect_valid && (r_state != S_BOOT);
    assign w_outstanding = ((r_state == S_WAIT) && !mem_rvalid) || (w_req && mem_ack);
    assign w_accept      = (r_state == S_WAIT) && mem_rvalid && !r_drop && !w_redirect;
    assign w_consume     = (r_state == S_DRAIN) && r_if_valid && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_redirect) begin
            w_next_state = w_outstanding ? S_WAIT : S_REQ;
        end else begin
            unique case (r_state)
                S_BOOT:  w_next_state = S_REQ;
                S_REQ: begin
                    if (!w_pc_legal) begin
                        w_next_state = S_FAULT;
                    end else if (mem_ack) begin
                        w_next_state = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        w_next_state = r_drop ? S_REQ : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_consume) begin
                        w_next_state = S_REQ;
                    end
                end
                S_FAULT: w_next_state = S_FAULT;
                default: w_next_state = S_BOOT;
            endcase
        end
    end

    always_comb begin
        mem_req    = w_req;
        mem_addr   = r_pc;
        if_valid   = r_if_valid;
        if_instr   = r_if_instr;
        if_pc      = r_if_pc;
        fault      = r_fault;
        fault_addr = r_fault_addr;
        dbg_state  = r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= IF_BASE_ADDR;
        end else if (w_redirect) begin
            r_pc <= redirect_addr;
        end else if (w_accept) begin
            r_pc <= r_pc + W_INC;
        end
    end

    // A redirect with a fetch in flight leaves exactly one stale response to discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else if (w_redirect) begin
            r_drop <= w_outstanding;
        end else if ((r_state == S_WAIT) && mem_rvalid) begin
            r_drop <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else if (w_redirect) begin
            r_if_valid <= 1'b0;
        end else if (w_accept) begin
            r_if_valid <= 1'b1;
            r_if_instr <= mem_rdata;
            r_if_pc    <= r_pc;
        end else if (w_consume) begin
            r_if_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else if (w_redirect) begin
            if (r_state == S_FAULT) begin
                r_fault <= 1'b0;
            end
        end else if ((r_state == S_REQ) && !w_pc_legal) begin
            r_fault      <= 1'b1;
            r_fault_addr <= r_pc;
        end
    end

endmodule
